// File: rtl/execute_mdu.sv
// execute_mdu: RV32 execute stage with operand forwarding, branch/JALR target
// generation, a combinational base ALU and a multi-cycle RV32M multiply/divide unit.
// Base ALU encoding (ALUCtrl_i): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU,
// 7 SLL, 8 SRL, 9 SRA; other codes give 0.
// Handshake: an M op is accepted in IDLE when ValidE_i & MExtE_i & ~FlushE_i; StallE_o
// stays high until the DONE cycle, during which upstream holds its inputs stable. In DONE
// ALUResultE_o carries the result and upstream advances at the following edge.
module execute_mdu #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  FlushE_i,
    input  logic                  ValidE_i,
    input  logic [DATA_WIDTH-1:0] RD1E_i,
    input  logic [DATA_WIDTH-1:0] RD2E_i,
    input  logic [DATA_WIDTH-1:0] PCE_i,
    input  logic [DATA_WIDTH-1:0] ImmExtE_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [1:0]            ForwardAE_i,
    input  logic [1:0]            ForwardBE_i,
    input  logic [3:0]            ALUCtrl_i,
    input  logic                  ALUSrc_i,
    input  logic                  JalrE_i,
    input  logic                  MExtE_i,
    input  logic [2:0]            MOpE_i,
    output logic [DATA_WIDTH-1:0] ALUResultE_o,
    output logic [DATA_WIDTH-1:0] WriteDataE_o,
    output logic [DATA_WIDTH-1:0] PCPlus4E_o,
    output logic [DATA_WIDTH-1:0] PCTargetE_o,
    output logic                  Zero_o,
    output logic                  StallE_o,
    output logic [1:0]            DbgStateE_o
);
    localparam int DW = DATA_WIDTH;
    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(DW + MUL_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   op_a_q, op_b_q, quo_q, rem_q, dvs_q, result_q;
    logic [1:0]      mop_q;

    logic [DW-1:0]   src_a, fwd_b, src_b, jalr_sum, alu_res;
    logic [SW-1:0]   shamt;
    logic            accept;

    // Forwarding muxes for operand A and store data / operand B
    always_comb begin
        case (ForwardAE_i)
            2'b01:   src_a = ResultW_i;
            2'b10:   src_a = ALUResultM_i;
            default: src_a = RD1E_i;
        endcase
        case (ForwardBE_i)
            2'b01:   fwd_b = ResultW_i;
            2'b10:   fwd_b = ALUResultM_i;
            default: fwd_b = RD2E_i;
        endcase
    end

    assign src_b        = ALUSrc_i ? ImmExtE_i : fwd_b;
    assign WriteDataE_o = fwd_b;
    assign PCPlus4E_o   = PCPlus4E_i;
    assign jalr_sum     = src_a + ImmExtE_i;
    assign PCTargetE_o  = JalrE_i ? (jalr_sum & {{(DW-1){1'b1}}, 1'b0}) : (PCE_i + ImmExtE_i);
    assign shamt        = src_b[SW-1:0];

    // Base ALU, zero latency
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            4'd0: alu_res = src_a + src_b;
            4'd1: alu_res = src_a - src_b;
            4'd2: alu_res = src_a & src_b;
            4'd3: alu_res = src_a | src_b;
            4'd4: alu_res = src_a ^ src_b;
            4'd5: alu_res = {{(DW-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd6: alu_res = {{(DW-1){1'b0}}, (src_a < src_b)};
            4'd7: alu_res = src_a << shamt;
            4'd8: alu_res = src_a >> shamt;
            4'd9: alu_res = $unsigned($signed(src_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Multiplier: live operands in IDLE (latency-1 case), latched ones afterwards.
    // Operands are extended to 2*DW bits so one unsigned multiply covers all sign modes.
    logic [DW-1:0]   mul_a, mul_b, mul_res;
    logic [1:0]      mul_op;
    logic            mul_a_sgn, mul_b_sgn;
    logic [2*DW-1:0] mul_a_ext, mul_b_ext, prod;

    assign mul_a     = (state_q == S_IDLE) ? src_a : op_a_q;
    assign mul_b     = (state_q == S_IDLE) ? src_b : op_b_q;
    assign mul_op    = (state_q == S_IDLE) ? MOpE_i[1:0] : mop_q;
    assign mul_a_sgn = (mul_op == 2'b01) || (mul_op == 2'b10);
    assign mul_b_sgn = (mul_op == 2'b01);
    assign mul_a_ext = {{DW{mul_a_sgn & mul_a[DW-1]}}, mul_a};
    assign mul_b_ext = {{DW{mul_b_sgn & mul_b[DW-1]}}, mul_b};
    assign prod      = mul_a_ext * mul_b_ext;
    assign mul_res   = (mul_op == 2'b00) ? prod[DW-1:0] : prod[2*DW-1:DW];

    // Divider: one restoring step per cycle on magnitudes, then sign/special-case fix-up
    logic [DW:0]   trial;
    logic [DW-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix, div_res, abs_a, abs_b;
    logic          div_signed, neg_a, neg_b, b_zero, acc_signed;

    assign trial      = {rem_q, quo_q[DW-1]} - {1'b0, dvs_q};
    assign rem_nxt    = trial[DW] ? {rem_q[DW-2:0], quo_q[DW-1]} : trial[DW-1:0];
    assign quo_nxt    = {quo_q[DW-2:0], ~trial[DW]};
    assign div_signed = ~mop_q[0];
    assign neg_a      = div_signed & op_a_q[DW-1];
    assign neg_b      = div_signed & op_b_q[DW-1];
    assign b_zero     = (op_b_q == '0);
    assign quo_fix    = b_zero ? '1 : ((neg_a ^ neg_b) ? (-quo_nxt) : quo_nxt);
    assign rem_fix    = b_zero ? op_a_q : (neg_a ? (-rem_nxt) : rem_nxt);
    assign div_res    = mop_q[1] ? rem_fix : quo_fix;
    assign acc_signed = ~MOpE_i[0];
    assign abs_a      = (acc_signed & src_a[DW-1]) ? (-src_a) : src_a;
    assign abs_b      = (acc_signed & src_b[DW-1]) ? (-src_b) : src_b;

    assign accept = (state_q == S_IDLE) & ValidE_i & MExtE_i & ~FlushE_i;

    // MDU control FSM with operand, work and result registers
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            mop_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else if (FlushE_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_a_q <= src_a;
                        op_b_q <= src_b;
                        mop_q  <= MOpE_i[1:0];
                        cnt_q  <= '0;
                        quo_q  <= abs_a;
                        rem_q  <= '0;
                        dvs_q  <= abs_b;
                        if (MOpE_i[2]) begin
                            state_q <= S_DIV;
                        end else if (MUL_LATENCY == 1) begin
                            result_q <= mul_res;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == CW'(MUL_LATENCY - 2)) begin
                        result_q <= mul_res;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DIV: begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    if (cnt_q == CW'(DW - 1)) begin
                        result_q <= div_res;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign StallE_o     = accept | (state_q == S_MUL) | (state_q == S_DIV);
    assign ALUResultE_o = (state_q == S_DONE) ? result_q : alu_res;
    assign Zero_o       = (ALUResultE_o == '0);
    assign DbgStateE_o  = state_q;

endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: directed vector bench for execute_mdu (DATA_WIDTH=32, MUL_LATENCY=2).
module tb_execute_mdu;
    logic        clk = 1'b0;
    logic        rstn_i, FlushE_i, ValidE_i, ALUSrc_i, JalrE_i, MExtE_i;
    logic [31:0] RD1E_i, RD2E_i, PCE_i, ImmExtE_i, PCPlus4E_i, ResultW_i, ALUResultM_i;
    logic [1:0]  ForwardAE_i, ForwardBE_i;
    logic [3:0]  ALUCtrl_i;
    logic [2:0]  MOpE_i;
    logic [31:0] ALUResultE_o, WriteDataE_o, PCPlus4E_o, PCTargetE_o;
    logic        Zero_o, StallE_o;
    logic [1:0]  DbgStateE_o;

    int n_total = 0;
    int n_pass  = 0;

    execute_mdu #(.DATA_WIDTH(32), .MUL_LATENCY(2)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .FlushE_i(FlushE_i), .ValidE_i(ValidE_i),
        .RD1E_i(RD1E_i), .RD2E_i(RD2E_i), .PCE_i(PCE_i), .ImmExtE_i(ImmExtE_i),
        .PCPlus4E_i(PCPlus4E_i), .ResultW_i(ResultW_i), .ALUResultM_i(ALUResultM_i),
        .ForwardAE_i(ForwardAE_i), .ForwardBE_i(ForwardBE_i), .ALUCtrl_i(ALUCtrl_i),
        .ALUSrc_i(ALUSrc_i), .JalrE_i(JalrE_i), .MExtE_i(MExtE_i), .MOpE_i(MOpE_i),
        .ALUResultE_o(ALUResultE_o), .WriteDataE_o(WriteDataE_o), .PCPlus4E_o(PCPlus4E_o),
        .PCTargetE_o(PCTargetE_o), .Zero_o(Zero_o), .StallE_o(StallE_o),
        .DbgStateE_o(DbgStateE_o)
    );

    // Clock: 10 time-unit period
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fa, fb;
        logic [31:0] rd1, rd2, resw, alum, imm, pc;
        logic        alusrc, jalr;
        logic [3:0]  ctrl;
        logic [31:0] exp_res, exp_tgt, exp_wd;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Apply one combinational vector at a negedge, sample mid-cycle, move to next negedge
    task automatic apply_vec(input int i);
        ForwardAE_i  = vecs[i].fa;
        ForwardBE_i  = vecs[i].fb;
        RD1E_i       = vecs[i].rd1;
        RD2E_i       = vecs[i].rd2;
        ResultW_i    = vecs[i].resw;
        ALUResultM_i = vecs[i].alum;
        ImmExtE_i    = vecs[i].imm;
        PCE_i        = vecs[i].pc;
        PCPlus4E_i   = vecs[i].pc + 32'd4;
        ALUSrc_i     = vecs[i].alusrc;
        JalrE_i      = vecs[i].jalr;
        ALUCtrl_i    = vecs[i].ctrl;
        ValidE_i     = 1'b1;
        MExtE_i      = 1'b0;
        #2;
        check($sformatf("vec%0d result", i), ALUResultE_o, vecs[i].exp_res);
        check($sformatf("vec%0d target", i), PCTargetE_o, vecs[i].exp_tgt);
        check($sformatf("vec%0d wdata", i), WriteDataE_o, vecs[i].exp_wd);
        check($sformatf("vec%0d zero", i), {31'd0, Zero_o}, {31'd0, (vecs[i].exp_res == 32'd0)});
        check($sformatf("vec%0d pcplus4", i), PCPlus4E_o, vecs[i].pc + 32'd4);
        check($sformatf("vec%0d stall", i), {31'd0, StallE_o}, 32'd0);
        @(negedge clk);
    endtask

    // Issue one M op at a negedge, count stall cycles (bounded), check DONE-cycle result
    task automatic m_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp, input int exp_stall);
        int n;
        ForwardAE_i = 2'b00;
        ForwardBE_i = 2'b00;
        ALUSrc_i    = 1'b0;
        JalrE_i     = 1'b0;
        ALUCtrl_i   = 4'd0;
        RD1E_i      = a;
        RD2E_i      = b;
        MOpE_i      = op;
        ValidE_i    = 1'b1;
        MExtE_i     = 1'b1;
        n = 0;
        #2;
        while (StallE_o && n < 100) begin
            n++;
            @(negedge clk);
            #2;
        end
        check({name, " stall"}, n, exp_stall);
        check({name, " result"}, ALUResultE_o, exp);
        check({name, " zero"}, {31'd0, Zero_o}, {31'd0, (exp == 32'd0)});
        ValidE_i = 1'b0;
        MExtE_i  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Vector table: fa fb rd1 rd2 resw alum imm pc alusrc jalr ctrl exp_res exp_tgt exp_wd
        vecs[0]  = '{2'b01, 2'b00, 32'd1, 32'h55, 32'd7, 32'd9, 32'd3, 32'h100, 1'b1, 1'b0, 4'd0, 32'd10, 32'h103, 32'h55};
        vecs[1]  = '{2'b10, 2'b00, 32'd1, 32'h55, 32'd7, 32'd9, 32'd3, 32'h100, 1'b1, 1'b0, 4'd0, 32'd12, 32'h103, 32'h55};
        vecs[2]  = '{2'b11, 2'b00, 32'd1, 32'h55, 32'd7, 32'd9, 32'd3, 32'h100, 1'b1, 1'b0, 4'd0, 32'd4, 32'h103, 32'h55};
        vecs[3]  = '{2'b00, 2'b00, 32'h1001, 32'd0, 32'd0, 32'd0, 32'd4, 32'h100, 1'b1, 1'b1, 4'd0, 32'h1005, 32'h1004, 32'd0};
        vecs[4]  = '{2'b00, 2'b00, 32'h1001, 32'd0, 32'd0, 32'd0, 32'd4, 32'h100, 1'b1, 1'b0, 4'd0, 32'h1005, 32'h104, 32'd0};
        vecs[5]  = '{2'b00, 2'b01, 32'd5, 32'd0, 32'd5, 32'd0, 32'd0, 32'h200, 1'b0, 1'b0, 4'd1, 32'd0, 32'h200, 32'd5};
        vecs[6]  = '{2'b00, 2'b10, 32'hF0F0, 32'd0, 32'd0, 32'h0FF0, 32'd0, 32'h300, 1'b0, 1'b0, 4'd2, 32'h00F0, 32'h300, 32'h0FF0};
        vecs[7]  = '{2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h10, 32'd0, 1'b0, 1'b0, 4'd5, 32'd1, 32'h10, 32'd1};
        vecs[8]  = '{2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h10, 32'd0, 1'b0, 1'b0, 4'd6, 32'd0, 32'h10, 32'd1};
        vecs[9]  = '{2'b00, 2'b00, 32'h80000000, 32'd7, 32'd0, 32'd0, 32'd4, 32'h1000, 1'b1, 1'b0, 4'd9, 32'hF8000000, 32'h1004, 32'd7};
        vecs[10] = '{2'b00, 2'b00, 32'd1, 32'd31, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd7, 32'h80000000, 32'd0, 32'd31};
        vecs[11] = '{2'b00, 2'b00, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 1'b1, 1'b1, 4'd0, 32'd1, 32'd0, 32'd0};

        // Reset block
        rstn_i = 1'b0; FlushE_i = 1'b0; ValidE_i = 1'b0; MExtE_i = 1'b0; MOpE_i = 3'd0;
        ALUSrc_i = 1'b0; JalrE_i = 1'b0; ALUCtrl_i = 4'd0; ForwardAE_i = 2'b00; ForwardBE_i = 2'b00;
        RD1E_i = '0; RD2E_i = '0; PCE_i = '0; ImmExtE_i = '0; PCPlus4E_i = '0;
        ResultW_i = '0; ALUResultM_i = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset state", {30'd0, DbgStateE_o}, 32'd0);
        check("reset stall", {31'd0, StallE_o}, 32'd0);
        check("reset result", ALUResultE_o, 32'd0);
        @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);

        // Combinational table: forwarding, JALR, ALU ops
        for (int i = 0; i < 12; i++) apply_vec(i);

        // Multiply: latency 2
        m_op("MUL",    32'hFFFFFFFF, 32'd2, 3'd0, 32'hFFFFFFFE, 2);
        m_op("MULHU",  32'hFFFFFFFF, 32'd2, 3'd3, 32'h00000001, 2);
        m_op("MULH",   32'hFFFFFFFF, 32'd2, 3'd1, 32'hFFFFFFFF, 2);
        m_op("MULHSU", 32'hFFFFFFFF, 32'd2, 3'd2, 32'hFFFFFFFF, 2);
        m_op("MULH2",  32'h80000000, 32'h80000000, 3'd1, 32'h40000000, 2);

        // Divide: DW+1 stall cycles regardless of operands
        m_op("DIV",      32'hFFFFFFF9, 32'd2, 3'd4, 32'hFFFFFFFD, 33);
        m_op("REM",      32'hFFFFFFF9, 32'd2, 3'd6, 32'hFFFFFFFF, 33);
        m_op("DIVU0",    32'd100, 32'd0, 3'd5, 32'hFFFFFFFF, 33);
        m_op("REMU0",    32'd100, 32'd0, 3'd7, 32'd100, 33);
        m_op("DIVOVF",   32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000, 33);
        m_op("REMOVF",   32'h80000000, 32'hFFFFFFFF, 3'd6, 32'd0, 33);
        m_op("REM0",     32'hFFFFFFF9, 32'd0, 3'd6, 32'hFFFFFFF9, 33);
        m_op("DIVUBIG",  32'hFFFFFFFF, 32'h80000000, 3'd5, 32'd1, 33);
        m_op("REMUBIG",  32'hFFFFFFFF, 32'h80000000, 3'd7, 32'h7FFFFFFF, 33);
        m_op("DIVNEGB",  32'd100, 32'hFFFFFFF9, 3'd4, 32'hFFFFFFF2, 33);

        // Back-to-back: DIV then MUL with only the DONE cycle between them
        m_op("B2B DIV", 32'd1000, 32'd7, 3'd4, 32'd142, 33);
        m_op("B2B MUL", 32'd1000, 32'd7, 3'd0, 32'd7000, 2);
        #2;
        check("B2B no reissue", {31'd0, StallE_o}, 32'd0);
        @(negedge clk);

        // Flush at DIV cycle 10
        RD1E_i = 32'd50; RD2E_i = 32'd3; MOpE_i = 3'd4; ValidE_i = 1'b1; MExtE_i = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check("flush pre stall", {31'd0, StallE_o}, 32'd1);
        FlushE_i = 1'b1; ValidE_i = 1'b0; MExtE_i = 1'b0;
        @(negedge clk);
        FlushE_i = 1'b0;
        #2;
        check("flush stall", {31'd0, StallE_o}, 32'd0);
        check("flush state", {30'd0, DbgStateE_o}, 32'd0);
        @(negedge clk);
        m_op("post flush MUL", 32'd6, 32'd7, 3'd0, 32'd42, 2);

        // Reset in the middle of a MUL
        RD1E_i = 32'd3; RD2E_i = 32'd5; MOpE_i = 3'd0; ValidE_i = 1'b1; MExtE_i = 1'b1;
        @(negedge clk);
        #2;
        check("midmul stall", {31'd0, StallE_o}, 32'd1);
        rstn_i = 1'b0; ValidE_i = 1'b0; MExtE_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
        #2;
        check("rst stall", {31'd0, StallE_o}, 32'd0);
        check("rst state", {30'd0, DbgStateE_o}, 32'd0);
        @(negedge clk);
        apply_vec(0);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time bound in case the stimulus itself wedges
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
